// File: rtl/mem_burst_arb_pkg.sv
// Shared types and default widths for the two-port memory burst arbiter.
// Imported by mem_burst_arbiter and rr_pick2.
package mem_burst_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef logic req_idx_t;

    function automatic req_idx_t other_req(input req_idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/mem_burst_arbiter_rr_pick2.sv
// Two-way round-robin winner select; the priority pointer lives in the parent.
module rr_pick2
    import mem_burst_arb_pkg::*;
(
    input  logic     req0_i,
    input  logic     req1_i,
    input  req_idx_t ptr_i,
    output logic     valid_o,
    output req_idx_t winner_o
);

    assign valid_o = req0_i | req1_i;

    always_comb begin
        winner_o = 1'b0;
        if (req0_i && req1_i) begin
            winner_o = ptr_i;
        end else if (req1_i) begin
            winner_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin burst arbiter for two requesters sharing one memory port.
// Optional MEM_BURST_ARB_ABORT_EN: owner dropping req ends the burst early.
module mem_burst_arbiter
    import mem_burst_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int LEN_WIDTH  = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [LEN_WIDTH-1:0]  len0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  grant0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [LEN_WIDTH-1:0]  len1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  grant1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q, state_d;
    req_idx_t              owner_q;
    req_idx_t              ptr_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  rvalid0_q, rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    logic     pick_vld;
    req_idx_t pick_win;
    logic     start;
    logic     last_beat;
    logic     burst_done;

    rr_pick2 u_pick (
        .req0_i  (req0),
        .req1_i  (req1),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .winner_o(pick_win)
    );

    assign start     = (state_q == IDLE) && pick_vld;
    assign last_beat = (cnt_q == len_q);

`ifdef MEM_BURST_ARB_ABORT_EN
    logic req_own;
    assign req_own    = owner_q ? req1 : req0;
    // the beat in flight still completes; only the following ones are dropped
    assign burst_done = last_beat || !req_own;
`else
    assign burst_done = last_beat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_vld) state_d = BURST;
            BURST:   if (burst_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == BURST) begin
            grant0   = (owner_q == 1'b0);
            grant1   = (owner_q == 1'b1);
            mem_addr = base_q + ADDR_WIDTH'(cnt_q);
            mem_wen  = we_q;
            mem_ren  = !we_q;
            if (we_q) begin
                mem_wdata = owner_q ? wdata1 : wdata0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            if (start) begin
                owner_q <= pick_win;
                we_q    <= pick_win ? we1 : we0;
                base_q  <= pick_win ? addr1 : addr0;
                len_q   <= pick_win ? len1 : len0;
                cnt_q   <= '0;
            end
            if (state_q == BURST) begin
                cnt_q <= cnt_q + 1'b1;
                if (burst_done) begin
                    ptr_q <= other_req(owner_q);
                end
            end
            rvalid0_q <= mem_ren && (owner_q == 1'b0);
            rvalid1_q <= mem_ren && (owner_q == 1'b1);
            if (mem_ren && (owner_q == 1'b0)) begin
                rdata0_q <= mem_rdata;
            end
            if (mem_ren && (owner_q == 1'b1)) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
